// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Sequencing controller for the 5-stage MIPS pipeline. It produces the
//   PC / IF/ID / ID/EX / EX/MEM / MEM/WB enable and flush strobes. It handles
//   memory wait states (ihit/dhit), load-use hazards and EX-resolved branches,
//   and it holds a sticky halt once a halt instruction leaves MEM.
// Ports
//   CLK, nRST            : clock, synchronous active-low reset
//   ihit, dhit           : fetch / data access complete this cycle
//   mem_dREN/dWEN/halt   : MEM-stage load / store / halt
//   ex_dREN, ex_dest     : EX-stage load and its destination register
//   id_rs, id_rt,
//   id_uses_rt           : IF/ID source registers
//   ex_br_taken          : EX-stage redirect (taken branch or jump)
//   *_en / *_flush       : latch strobes (flush wins over enable)
//   dmem_ren, dmem_wen   : gated data-memory request
//   halt                 : sticky halt (registered)
//   stall_cnt            : saturating count of stalled cycles
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  input  logic             ex_dREN,
  input  logic [4:0]       ex_dest,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_br_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             dmem_ren,
  output logic             dmem_wen,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t           r_state;
  logic             r_dhit_seen;
  logic             r_halt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_mem_req, w_mem_busy, w_advance, w_ldu, w_ldu_bubble, w_stall;

  // dhit_seen remembers a completed data access while waiting on ihit, so
  // the request is not reissued and the MEM stage no longer counts as busy.
  assign w_mem_req    = mem_dREN | mem_dWEN;
  assign w_mem_busy   = w_mem_req & ~dhit & ~r_dhit_seen;
  assign w_advance    = ihit & ~w_mem_busy;
  assign w_ldu        = ex_dREN & (ex_dest != 5'd0) &
                        ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));
  // A branch squashes the dependent instruction anyway, so it masks ldu.
  assign w_ldu_bubble = w_advance & ~ex_br_taken & w_ldu;
  assign w_stall      = ~w_advance | w_ldu_bubble;

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    dmem_ren    = 1'b0;
    dmem_wen    = 1'b0;
    if (!nRST) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (r_state == RUN) begin
      dmem_ren = mem_dREN & ~r_dhit_seen;
      dmem_wen = mem_dWEN & ~r_dhit_seen;
      if (!w_advance) begin
        // Freeze; bubble into WB so the held MEM/WB instruction does not
        // write the register file a second time.
        memwb_flush = 1'b1;
      end else if (ex_br_taken) begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (w_ldu) begin
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
      end
    end
  end

  assign halt      = r_halt & nRST;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_halt      <= 1'b0;
      r_dhit_seen <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_advance)
            r_dhit_seen <= 1'b0;
          else if (dhit)
            r_dhit_seen <= 1'b1;
          if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (w_advance && mem_halt) begin
            r_state <= HALTED;
            r_halt  <= 1'b1;
          end
        end
        HALTED: begin
          r_state <= HALTED;
          r_halt  <= 1'b1;
        end
        default: begin
          r_state <= RUN;
          r_halt  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS datapath. It generates the enable and flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It resolves three conditions:

- instruction- and data-memory wait states (ihit/dhit),
- load-use hazards between decode and execute,
- taken branches and jumps resolved in execute.

It also holds the processor in a sticky halt once a halt instruction retires from MEM.

## Interface
Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter

Ports:
- CLK  in  1  system clock, all state updates on rising edge
- nRST  in  1  synchronous active-low reset
- ihit  in  1  instruction fetch for current PC complete this cycle
- dhit  in  1  data access for MEM-stage instruction complete this cycle
- mem_dREN  in  1  MEM-stage instruction is a load
- mem_dWEN  in  1  MEM-stage instruction is a store
- mem_halt  in  1  MEM-stage instruction is halt
- ex_dREN  in  1  EX-stage instruction is a load (ID/EX dREN output)
- ex_dest  in  5  EX-stage destination register (after RegDst/jal select)
- id_rs  in  5  rs field of IF/ID instruction
- id_rt  in  5  rt field of IF/ID instruction
- id_uses_rt  in  1  IF/ID instruction reads rt as a source
- ex_br_taken  in  1  EX-stage beq/bne taken, or j/jal/jr
- pc_en  out  1  PC loads next value
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch captures inputs
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch loads bubble (all fields 0, including RegWr/MemWr/dREN/dWEN/halt); flush overrides enable
- dmem_ren, dmem_wen  out  1 each  gated data-memory request to cache
- halt  out  1  sticky processor halt
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
State machine: RUN, HALTED. Reset state is RUN.

In RUN, the controller evaluates the following terms each cycle:
- mem_req = mem_dREN | mem_dWEN.
- dhit_seen is a registered flag. It is set when dhit=1 and advance=0. It is cleared when advance=1.
- mem_busy = mem_req & ~dhit & ~dhit_seen.
- advance = ihit & ~mem_busy.
- ldu = ex_dREN & (ex_dest != 0) & ((ex_dest == id_rs) | (id_uses_rt & ex_dest == id_rt)).

Memory request outputs:
- dmem_ren = mem_dREN & ~dhit_seen.
- dmem_wen = mem_dWEN & ~dhit_seen.
- This prevents a second access while waiting for ihit.

Latch control in RUN, in priority order:
1. advance=0: all enables 0, memwb_flush=1, other flushes 0. This is a freeze with a WB bubble so no duplicate register write occurs.
2. advance & ex_br_taken: all enables 1. ifid_flush=1 and idex_flush=1 squash the two younger instructions. The PC takes the target. ldu is ignored.
3. advance & ldu: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, memwb_en=1. This inserts one bubble. The next cycle re-evaluates with the load in MEM, so ldu is 0.
4. advance otherwise: all enables 1, all flushes 0.

Halt handling:
- advance & mem_halt moves the state to HALTED on the next edge.
- In HALTED: all enables 0, all flushes 0, dmem_ren=0, dmem_wen=0, halt=1.
- HALTED is left only by reset.

stall_cnt:
- Increments in RUN on every cycle with advance=0 or ldu-bubble (case 3).
- Saturates at all-ones.
- Frozen in HALTED.

Reset (nRST=0 at an edge): state goes to RUN, dhit_seen=0, stall_cnt=0.

Outputs while nRST=0:
- pc_en, ifid_en, idex_en, exmem_en and memwb_en = 0.
- All four flushes = 1.
- dmem_ren=0, dmem_wen=0, halt=0.

Reset asserted mid-stall or mid-halt discards all state.

## Timing
- Enables, flushes and dmem_ren/dmem_wen are combinational from the inputs and current state. Latches act on them at the next CLK edge.
- halt is registered. It rises one cycle after the edge on which the halt instruction advanced out of MEM.
- dhit_seen and stall_cnt update at the edge following the qualifying cycle.
- Load-use costs exactly 1 cycle.
- A taken branch costs 2 squashed slots with no freeze.
- Data stall length equals cycles until dhit, plus cycles until ihit if ihit arrives later.
- Simultaneous dhit and ihit: advance the same cycle, dhit_seen stays 0.
- dhit with ihit=0: dhit_seen=1 next cycle, requests gated, freeze continues until ihit.

## Test plan
- Reset: hold nRST=0 for 2 cycles with ihit=1 → all enables 0, all flushes 1, halt=0, stall_cnt=0. Release → all enables 1 on the first cycle with ihit=1.
- Load-use: ex_dREN=1, ex_dest=8, id_rs=8, ihit=1 → pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1, stall_cnt +1. Repeat with ex_dest=0 → no stall.
- Branch priority: ex_br_taken=1 together with a ldu condition, ihit=1 → ifid_flush=1, idex_flush=1, pc_en=1, stall_cnt unchanged.
- Data wait: mem_dREN=1, dhit low 3 cycles then high with ihit=0, then ihit high 2 cycles later.
  - All enables 0 and memwb_flush=1 for 5 cycles.
  - dmem_ren drops the cycle after dhit.
  - Advance occurs on the ihit cycle.
  - stall_cnt=5.
- Halt: mem_halt=1 with ihit=1 → halt=1 the next cycle and stays high; all enables stay 0 for 10 cycles regardless of inputs; nRST=0 clears halt.
- Saturation: force 2^CNT_W+3 stalled cycles with CNT_W=4 → stall_cnt holds at 15.
